// File: rtl/led_mode_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// led_mode_ctrl_pkg
// Shared definitions for the LED mode controller:
//   - mode codes (OFF, ON, SLOW, FAST, BREATH) and the mode bus width
//   - MODE_LAST, the mode after which a step wraps back to OFF
//   - PWM frame constants for the breathing mode
//   - cnt_width(), the counter sizing helper
// Configuration macro: LED_MODE_BREATH_EN (adds BREATH after FAST).
// ---------------------------------------------------------------------------
package led_mode_ctrl_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF    = 3'd0,
    MODE_ON     = 3'd1,
    MODE_SLOW   = 3'd2,
    MODE_FAST   = 3'd3,
    MODE_BREATH = 3'd4
  } mode_e;

`ifdef LED_MODE_BREATH_EN
  localparam mode_e MODE_LAST = MODE_BREATH;
`else
  localparam mode_e MODE_LAST = MODE_FAST;
`endif

  // A PWM frame is 100 slots; duty runs 0..100, so duty=100 means always lit.
  localparam int PWM_SLOTS = 100;
  localparam int DUTY_MAX  = 100;

  // Width needed to hold 0..term without wrapping early; never below 1 bit.
  function automatic int cnt_width(input int term);
    return (term < 1) ? 1 : $clog2(term + 1);
  endfunction

endpackage

// File: rtl/led_mode_ctrl_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Free-running divider: the counter runs 0..div-1 and tick is high for the
// single cycle spent at the terminal count. clr restarts the count at 0 so a
// new LED mode sees whole periods from its entry cycle.
// Ports:
//   sclk  in  system clock, rising edge
//   nrst  in  asynchronous active-low reset
//   clr   in  synchronous restart of the count
//   tick  out one-cycle pulse every div cycles (constant 1 when div = 1)
// ---------------------------------------------------------------------------
module tick_gen
  import led_mode_ctrl_pkg::*;
#(
  parameter int div = 50_000
) (
  input  logic sclk,
  input  logic nrst,
  input  logic clr,
  output logic tick
);

  localparam int               CNT_W = cnt_width(div - 1);
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(div - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_mode_ctrl.sv
// ---------------------------------------------------------------------------
// led_mode_ctrl
// Steps the board LED through OFF -> ON -> SLOW blink -> FAST blink
// (-> BREATH) -> OFF, one mode per cycle that step_flag is high. Key
// long-press repeat pulses therefore walk through the modes on their own.
// Ports:
//   sclk       in   system clock, rising edge
//   nrst       in   asynchronous active-low reset
//   step_flag  in   one step per high cycle
//   led        out  registered LED drive, 1 = lit
//   mode       out  registered current mode code
// Configuration macro: LED_MODE_BREATH_EN
//   defined   : BREATH mode (PWM triangle fade) follows FAST, and the
//               breath_ms parameter exists
//   undefined : FAST wraps to OFF; no PWM or duty logic is built
// ---------------------------------------------------------------------------
module led_mode_ctrl
  import led_mode_ctrl_pkg::*;
#(
  parameter int sclk_freq = 50_000_000,
  parameter int slow_ms   = 500,
  parameter int fast_ms   = 100
`ifdef LED_MODE_BREATH_EN
  ,
  parameter int breath_ms = 2000
`endif
) (
  input  logic              sclk,
  input  logic              nrst,
  input  logic              step_flag,
  output logic              led,
  output logic [MODE_W-1:0] mode
);

  // Blink half-period counter, sized for the longer of the two half periods.
  localparam int HALF_TERM_MAX = ((slow_ms > fast_ms) ? slow_ms : fast_ms) - 1;
  localparam int HALF_W        = cnt_width(HALF_TERM_MAX);
  localparam logic [HALF_W-1:0] SLOW_TERM = HALF_W'(slow_ms - 1);
  localparam logic [HALF_W-1:0] FAST_TERM = HALF_W'(fast_ms - 1);

  mode_e             mode_q;
  mode_e             mode_d;
  logic              phase_q;
  logic              phase_d;
  logic [HALF_W-1:0] half_cnt_q;
  logic [HALF_W-1:0] half_cnt_d;
  logic              led_q;
  logic              led_d;

  logic              ms_tick;
  logic              blink_mode;
  logic [HALF_W-1:0] half_term;

  // Every step restarts the ms grid so blink periods are exact from entry.
  tick_gen #(
    .div (sclk_freq / 1000)
  ) u_ms_tick (
    .sclk (sclk),
    .nrst (nrst),
    .clr  (step_flag),
    .tick (ms_tick)
  );

`ifdef LED_MODE_BREATH_EN
  // Duty advances once every breath_ms/200 ms, giving 200 steps per full
  // dark -> bright -> dark cycle.
  localparam int DUTY_MS_TERM = (breath_ms / 200) - 1;
  localparam int DUTY_MS_W    = cnt_width(DUTY_MS_TERM);
  localparam int SLOT_W       = cnt_width(PWM_SLOTS - 1);
  localparam int DUTY_W       = cnt_width(DUTY_MAX);

  localparam logic [DUTY_MS_W-1:0] DUTY_MS_LAST = DUTY_MS_W'(DUTY_MS_TERM);
  localparam logic [SLOT_W-1:0]    SLOT_LAST    = SLOT_W'(PWM_SLOTS - 1);
  localparam logic [DUTY_W-1:0]    DUTY_TOP     = DUTY_W'(DUTY_MAX);

  logic                 slot_tick;
  logic [SLOT_W-1:0]    slot_q;
  logic [SLOT_W-1:0]    slot_d;
  logic [DUTY_W-1:0]    duty_q;
  logic [DUTY_W-1:0]    duty_d;
  logic [DUTY_MS_W-1:0] duty_ms_q;
  logic [DUTY_MS_W-1:0] duty_ms_d;
  logic                 rising_q;
  logic                 rising_d;

  // 10 us PWM slot tick, realigned on every step like the ms tick.
  tick_gen #(
    .div (sclk_freq / 100_000)
  ) u_slot_tick (
    .sclk (sclk),
    .nrst (nrst),
    .clr  (step_flag),
    .tick (slot_tick)
  );
`endif

  assign blink_mode = (mode_q == MODE_SLOW) || (mode_q == MODE_FAST);
  assign half_term  = (mode_q == MODE_SLOW) ? SLOW_TERM : FAST_TERM;

  // Next-state logic. The LED value is derived from the registered mode, so
  // the LED follows a mode change one cycle later. A step always wins over
  // any blink toggle or duty step landing on the same edge: the new mode
  // starts lit with every counter cleared.
  always_comb begin
    mode_d     = mode_q;
    phase_d    = phase_q;
    half_cnt_d = half_cnt_q;
    led_d      = 1'b0;
`ifdef LED_MODE_BREATH_EN
    slot_d     = slot_q;
    duty_d     = duty_q;
    duty_ms_d  = duty_ms_q;
    rising_d   = rising_q;
`endif

    unique case (mode_q)
      MODE_OFF:  led_d = 1'b0;
      MODE_ON:   led_d = 1'b1;
      MODE_SLOW,
      MODE_FAST: led_d = phase_q;
`ifdef LED_MODE_BREATH_EN
      MODE_BREATH: led_d = (SLOT_W'(slot_q) < SLOT_W'(duty_q));
`endif
      default:   led_d = 1'b0;
    endcase

    if (blink_mode && ms_tick) begin
      if (half_cnt_q == half_term) begin
        phase_d    = ~phase_q;
        half_cnt_d = '0;
      end else begin
        half_cnt_d = half_cnt_q + 1'b1;
      end
    end

`ifdef LED_MODE_BREATH_EN
    // Triangle duty: 0,1..100,99..1,0,1.. with the frame slot sweeping 0..99.
    if (mode_q == MODE_BREATH) begin
      if (slot_tick) begin
        slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
      end
      if (ms_tick) begin
        if (duty_ms_q == DUTY_MS_LAST) begin
          duty_ms_d = '0;
          if (rising_q) begin
            if (duty_q == DUTY_TOP) begin
              duty_d   = DUTY_TOP - 1'b1;
              rising_d = 1'b0;
            end else begin
              duty_d = duty_q + 1'b1;
            end
          end else begin
            if (duty_q == '0) begin
              duty_d   = DUTY_W'(1);
              rising_d = 1'b1;
            end else begin
              duty_d = duty_q - 1'b1;
            end
          end
        end else begin
          duty_ms_d = duty_ms_q + 1'b1;
        end
      end
    end
`endif

    if (step_flag) begin
      mode_d     = (mode_q == MODE_LAST) ? MODE_OFF : mode_e'(mode_q + 3'd1);
      phase_d    = 1'b1;
      half_cnt_d = '0;
`ifdef LED_MODE_BREATH_EN
      slot_d     = '0;
      duty_d     = '0;
      duty_ms_d  = '0;
      rising_d   = 1'b1;
`endif
    end
  end

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      mode_q     <= MODE_OFF;
      phase_q    <= 1'b1;
      half_cnt_q <= '0;
      led_q      <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      phase_q    <= phase_d;
      half_cnt_q <= half_cnt_d;
      led_q      <= led_d;
    end
  end

`ifdef LED_MODE_BREATH_EN
  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      slot_q    <= '0;
      duty_q    <= '0;
      duty_ms_q <= '0;
      rising_q  <= 1'b1;
    end else begin
      slot_q    <= slot_d;
      duty_q    <= duty_d;
      duty_ms_q <= duty_ms_d;
      rising_q  <= rising_d;
    end
  end
`endif

  assign led  = led_q;
  assign mode = mode_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_mode_ctrl
// Drives led_mode_ctrl with 100 cycles per ms (slow 5 ms, fast 2 ms, breath
// 200 ms) and compares mode/led on every falling edge against a model that
// derives the LED from the current mode and the cycles elapsed since entry.
// ---------------------------------------------------------------------------
module tb_led_mode_ctrl;

  localparam int CYC_PER_MS = 100;
  localparam int SLOW_HALF  = 5 * CYC_PER_MS;
  localparam int FAST_HALF  = 2 * CYC_PER_MS;
`ifdef LED_MODE_BREATH_EN
  localparam int LAST_MODE  = 4;
`else
  localparam int LAST_MODE  = 3;
`endif

  logic       sclk = 1'b0;
  logic       nrst = 1'b0;
  logic       step_flag = 1'b0;
  logic       led;
  logic [2:0] mode;

  int tests_run    = 0;
  int tests_failed = 0;

  int m_mode = 0;
  int m_t    = 0;
  int m_led  = 0;

  led_mode_ctrl #(
    .sclk_freq (100_000),
    .slow_ms   (5),
    .fast_ms   (2)
`ifdef LED_MODE_BREATH_EN
    ,
    .breath_ms (200)
`endif
  ) dut (
    .sclk      (sclk),
    .nrst      (nrst),
    .step_flag (step_flag),
    .led       (led),
    .mode      (mode)
  );

  always #5 sclk = ~sclk;

  // Expected LED for a mode that has been active for t cycles.
  function automatic int ledRule(input int md, input int t);
    int n;
    int duty;
    case (md)
      0: return 0;
      1: return 1;
      2: return (((t / SLOW_HALF) % 2) == 0) ? 1 : 0;
      3: return (((t / FAST_HALF) % 2) == 0) ? 1 : 0;
      4: begin
        n    = (t / CYC_PER_MS) % 200;
        duty = (n <= 100) ? n : 200 - n;
        return ((t % 100) < duty) ? 1 : 0;
      end
      default: return 0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Hold step_flag at stepVal for the given number of rising edges, leaving
  // the bench 1 time unit after the last edge with step_flag low.
  task automatic applyStimulus(input logic stepVal, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step_flag = stepVal;
      @(posedge sclk);
      #1;
    end
    step_flag = 1'b0;
  endtask

  task automatic countLitFrame(output int lit);
    lit = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0, 1);
      lit += int'(led);
    end
  endtask

  // Model: registered LED reflects the mode and its age before this edge.
  always @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      m_mode = 0;
      m_t    = 0;
      m_led  = 0;
    end else begin
      m_led = ledRule(m_mode, m_t);
      if (step_flag) begin
        m_mode = (m_mode == LAST_MODE) ? 0 : m_mode + 1;
        m_t    = 0;
      end else begin
        m_t++;
      end
    end
  end

  always @(negedge sclk) begin
    if (nrst) begin
      checkOutput("model_mode", int'(mode), m_mode);
      checkOutput("model_led", int'(led), m_led);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lit;

    repeat (3) @(posedge sclk);
    #1;
    nrst = 1'b1;
    checkOutput("reset_mode", int'(mode), 0);
    checkOutput("reset_led", int'(led), 0);

    // Walk the modes, timing SLOW and FAST halves on the way.
    applyStimulus(1'b1, 1);
    checkOutput("step_to_on", int'(mode), 1);
    applyStimulus(1'b0, 1);
    checkOutput("on_led", int'(led), 1);

    applyStimulus(1'b1, 1);
    checkOutput("step_to_slow", int'(mode), 2);
    applyStimulus(1'b0, 1);
    checkOutput("slow_first_lit", int'(led), 1);
    applyStimulus(1'b0, 499);
    checkOutput("slow_last_lit", int'(led), 1);
    applyStimulus(1'b0, 1);
    checkOutput("slow_first_dark", int'(led), 0);
    applyStimulus(1'b0, 499);
    checkOutput("slow_last_dark", int'(led), 0);
    applyStimulus(1'b0, 1);
    checkOutput("slow_relit", int'(led), 1);

    applyStimulus(1'b1, 1);
    checkOutput("step_to_fast", int'(mode), 3);
    applyStimulus(1'b0, 1);
    checkOutput("fast_first_lit", int'(led), 1);
    applyStimulus(1'b0, 199);
    checkOutput("fast_last_lit", int'(led), 1);
    applyStimulus(1'b0, 1);
    checkOutput("fast_first_dark", int'(led), 0);

`ifdef LED_MODE_BREATH_EN
    applyStimulus(1'b1, 1);
    checkOutput("step_to_breath", int'(mode), 4);
    applyStimulus(1'b0, 4999);
    countLitFrame(lit);
    checkOutput("breath_50ms_lit", lit, 50);
    applyStimulus(1'b0, 4900);
    countLitFrame(lit);
    checkOutput("breath_100ms_lit", lit, 100);
    applyStimulus(1'b0, 9800);
    countLitFrame(lit);
    checkOutput("breath_199ms_lit", lit, 1);
    countLitFrame(lit);
    checkOutput("breath_200ms_lit", lit, 0);
`endif

    applyStimulus(1'b1, 1);
    checkOutput("wrap_to_off", int'(mode), 0);

    // Step lands on the SLOW toggle edge: FAST starts lit with a full half.
    applyStimulus(1'b1, 2);
    checkOutput("collide_slow", int'(mode), 2);
    applyStimulus(1'b0, 499);
    applyStimulus(1'b1, 1);
    checkOutput("collide_mode", int'(mode), 3);
    applyStimulus(1'b0, 1);
    checkOutput("collide_led", int'(led), 1);
    applyStimulus(1'b0, 199);
    checkOutput("collide_fast_last_lit", int'(led), 1);
    applyStimulus(1'b0, 1);
    checkOutput("collide_fast_dark", int'(led), 0);

    // Back-to-back step pulses from OFF.
    applyStimulus(1'b1, LAST_MODE - 2);
    checkOutput("back_to_off", int'(mode), 0);
    applyStimulus(1'b1, 3);
    checkOutput("back_to_back", int'(mode), 3);

    // Asynchronous reset while SLOW is lit.
    applyStimulus(1'b1, LAST_MODE);
    checkOutput("reenter_slow", int'(mode), 2);
    applyStimulus(1'b0, 10);
    checkOutput("slow_lit_pre_reset", int'(led), 1);
    #2;
    nrst = 1'b0;
    #1;
    checkOutput("async_reset_led", int'(led), 0);
    checkOutput("async_reset_mode", int'(mode), 0);
    repeat (2) @(posedge sclk);
    #1;
    nrst = 1'b1;
    applyStimulus(1'b0, 20);
    checkOutput("post_reset_mode", int'(mode), 0);
    checkOutput("post_reset_led", int'(led), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
